// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART word transmitter.
package uart_tx_pkg;

  localparam int unsigned BITS_PER_BYTE        = 8;
  localparam int unsigned WORD_BYTES           = 4;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } tx_state_e;

  // Map sample as sent on the wire, b3 first.
  typedef struct packed {
    logic [7:0] b3;
    logic [7:0] b2;
    logic [7:0] b1;
    logic [7:0] b0;
  } tx_word_t;

  function automatic logic [7:0] word_byte(input tx_word_t w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w.b3;
      2'd1:    b = w.b2;
      2'd2:    b = w.b1;
      default: b = w.b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_word_tx_if.sv
// Word handshake between the map FSM (master) and the UART stage (slave).
interface uart_word_tx_if;

  logic        random_write;
  logic [31:0] random_sequance;
  logic        write_complete;
  logic        busy;

  modport master (
    output random_write,
    output random_sequance,
    input  write_complete,
    input  busy
  );

  modport slave (
    input  random_write,
    input  random_sequance,
    output write_complete,
    output busy
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter; tick is high during the last cycle of each period.
module uart_baud_tick
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset1,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    if (clear || (cnt == LAST)) cnt_nxt = '0;
  end

  // tick is registered from the next count so it lines up with cnt == LAST.
  always_ff @(posedge clk or negedge reset1) begin
    if (!reset1) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// Sends one 32-bit map sample as four (or five with sync byte) 8N1 UART bytes, MSB byte first.
module uart_word_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit          HEADER_EN    = 1'b0,
  parameter logic [7:0]  HEADER_BYTE  = 8'hA5
) (
  input  logic           clk,
  input  logic           reset1,
  uart_word_tx_if.slave  bus,
  output logic           txd
);

  localparam int unsigned N_BYTES   = WORD_BYTES + (HEADER_EN ? 1 : 0);
  localparam logic [2:0]  LAST_BYTE = 3'(N_BYTES - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(BITS_PER_BYTE - 1);

  tx_state_e  state, state_nxt;
  tx_word_t   word_q, word_nxt;
  logic [2:0] bit_idx, bit_nxt;
  logic [2:0] byte_idx, byte_nxt;
  logic       txd_q, txd_nxt;
  logic       busy_q, busy_nxt;
  logic       wc_q, wc_nxt;

  logic       tick;
  logic       baud_clr_c;
  logic [1:0] data_idx_c;
  logic [7:0] cur_byte_c;
  logic [2:0] next_bit_c;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset1 (reset1),
    .clear  (baud_clr_c),
    .tick   (tick)
  );

  // Counter is held at zero while waiting so acceptance starts a fresh bit period.
  assign baud_clr_c = (state == IDLE) || (state == DONE);

  // With the sync byte in slot 0, data slots are shifted up by one.
  assign data_idx_c = HEADER_EN ? 2'(byte_idx - 3'd1) : byte_idx[1:0];
  assign cur_byte_c = (HEADER_EN && (byte_idx == 3'd0)) ? HEADER_BYTE
                                                        : word_byte(word_q, data_idx_c);
  assign next_bit_c = 3'(bit_idx + 3'd1);

  always_comb begin
    state_nxt = state;
    word_nxt  = word_q;
    bit_nxt   = bit_idx;
    byte_nxt  = byte_idx;
    txd_nxt   = txd_q;
    busy_nxt  = busy_q;
    wc_nxt    = wc_q;

    case (state)
      IDLE: begin
        txd_nxt  = 1'b1;
        busy_nxt = 1'b0;
        wc_nxt   = 1'b0;
        if (bus.random_write) begin
          word_nxt  = tx_word_t'(bus.random_sequance);
          byte_nxt  = 3'd0;
          bit_nxt   = 3'd0;
          busy_nxt  = 1'b1;
          txd_nxt   = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        if (tick) begin
          bit_nxt   = 3'd0;
          txd_nxt   = cur_byte_c[0];
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == LAST_BIT) begin
            txd_nxt   = 1'b1;
            state_nxt = STOP;
          end else begin
            bit_nxt = next_bit_c;
            txd_nxt = cur_byte_c[next_bit_c];
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (byte_idx == LAST_BYTE) begin
            wc_nxt    = 1'b1;
            state_nxt = DONE;
          end else begin
            byte_nxt  = 3'(byte_idx + 3'd1);
            txd_nxt   = 1'b0;
            state_nxt = START;
          end
        end
      end
      DONE: begin
        txd_nxt = 1'b1;
        if (!bus.random_write) begin
          wc_nxt    = 1'b0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        txd_nxt   = 1'b1;
        busy_nxt  = 1'b0;
        wc_nxt    = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset1) begin
    if (!reset1) begin
      state    <= IDLE;
      word_q   <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      wc_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      word_q   <= word_nxt;
      bit_idx  <= bit_nxt;
      byte_idx <= byte_nxt;
      txd_q    <= txd_nxt;
      busy_q   <= busy_nxt;
      wc_q     <= wc_nxt;
    end
  end

  assign txd                = txd_q;
  assign bus.busy           = busy_q;
  assign bus.write_complete = wc_q;

endmodule
